// File: rtl/riscv_constants.sv
// ----------------------------------------------------------------------------
// riscv_constants -- shared encodings for the RISC-V core slice.
//   ALU_FUNC_* : ALU operation select.
//   BR_FUNC_*  : branch comparison select.
//   MEM_FUNC_* : load/store width and sign select.
//   lsu_state_e: load/store unit FSM states.
// Helper functions normalise the memory function and compute the effective
// byte offset / misalignment of an access.
// ----------------------------------------------------------------------------
package riscv_constants;

  localparam logic [3:0] ALU_FUNC_ADD  = 4'b0000;
  localparam logic [3:0] ALU_FUNC_SUB  = 4'b0001;
  localparam logic [3:0] ALU_FUNC_AND  = 4'b0010;
  localparam logic [3:0] ALU_FUNC_OR   = 4'b0011;
  localparam logic [3:0] ALU_FUNC_XOR  = 4'b0100;

  localparam logic [2:0] BR_FUNC_BEQ   = 3'b000;
  localparam logic [2:0] BR_FUNC_BNE   = 3'b001;
  localparam logic [2:0] BR_FUNC_BLT   = 3'b100;
  localparam logic [2:0] BR_FUNC_BGE   = 3'b101;

  localparam logic [2:0] MEM_FUNC_B    = 3'b000;
  localparam logic [2:0] MEM_FUNC_H    = 3'b001;
  localparam logic [2:0] MEM_FUNC_W    = 3'b010;
  localparam logic [2:0] MEM_FUNC_BU   = 3'b100;
  localparam logic [2:0] MEM_FUNC_HU   = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10
  } lsu_state_e;

  // Any encoding outside the five legal ones behaves as a word access.
  function automatic logic [2:0] mem_func_norm(input logic [2:0] func);
    case (func)
      MEM_FUNC_B, MEM_FUNC_H, MEM_FUNC_W,
      MEM_FUNC_BU, MEM_FUNC_HU: return func;
      default:                  return MEM_FUNC_W;
    endcase
  endfunction

  // Byte offset actually used: halfwords drop bit 0, words drop both bits.
  function automatic logic [1:0] mem_off_align(input logic [2:0] func, input logic [1:0] off);
    case (func)
      MEM_FUNC_B, MEM_FUNC_BU: return off;
      MEM_FUNC_H, MEM_FUNC_HU: return {off[1], 1'b0};
      default:                 return 2'b00;
    endcase
  endfunction

  function automatic logic mem_misaligned(input logic [2:0] func, input logic [1:0] off);
    case (func)
      MEM_FUNC_B, MEM_FUNC_BU: return 1'b0;
      MEM_FUNC_H, MEM_FUNC_HU: return off[0];
      default:                 return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// ----------------------------------------------------------------------------
// riscv_lsu_align -- combinational lane steering for the LSU.
//   st_func/st_off/st_data -> be, wdata   (store-side byte enables and
//                                           lane-replicated write data)
//   ld_func/ld_off/ld_rdata -> ld_data    (addressed lane, sign/zero extended)
// Functions are expected already normalised (mem_func_norm).
// ----------------------------------------------------------------------------
module riscv_lsu_align
  import riscv_constants::*;
(
  input  logic [2:0]  st_func,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  input  logic [2:0]  ld_func,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Store side: enables follow the offset, data is replicated to every lane.
  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (st_func)
      MEM_FUNC_B, MEM_FUNC_BU: begin
        be    = 4'b0001 << st_off;
        wdata = {4{st_data[7:0]}};
      end
      MEM_FUNC_H, MEM_FUNC_HU: begin
        be    = 4'b0011 << st_off;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = st_data;
      end
    endcase
  end

  // Load side: pick the addressed lane then extend to 32 bits.
  always_comb begin
    ld_byte_s = ld_rdata[{ld_off, 3'b000} +: 8];
    ld_half_s = ld_rdata[{ld_off[1], 4'b0000} +: 16];
    case (ld_func)
      MEM_FUNC_B:  ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
      MEM_FUNC_BU: ld_data = {24'h000000, ld_byte_s};
      MEM_FUNC_H:  ld_data = {{16{ld_half_s[15]}}, ld_half_s};
      MEM_FUNC_HU: ld_data = {16'h0000, ld_half_s};
      default:     ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// ----------------------------------------------------------------------------
// riscv_lsu -- load/store unit between execute and a req/gnt/rvalid memory.
//   clk_in, rst_in (synchronous, active high)
//   execute side : valid_in, load_in, store_in, mem_func_in, addr_in,
//                  store_data_in -> result_out, done_out, busy_out,
//                  misaligned_out
//   memory side  : mem_req_out, mem_we_out, mem_addr_out, mem_be_out,
//                  mem_wdata_out <- mem_gnt_in, mem_rvalid_in, mem_rdata_in
// FSM IDLE -> REQ -> (store) IDLE | (load) WAIT -> IDLE. All outputs are
// registered. Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses
// are rejected with a misaligned_out pulse instead of being force-aligned.
// ----------------------------------------------------------------------------
module riscv_lsu
  import riscv_constants::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [2:0]  mem_func_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  mem_be_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_gnt_in,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in,
  output logic [31:0] result_out,
  output logic        done_out,
  output logic        busy_out,
  output logic        misaligned_out
);

  lsu_state_e  state_r;
  logic [2:0]  func_r;
  logic [1:0]  off_r;
  logic [2:0]  func_s;
  logic [1:0]  off_s;
  logic        misal_s;
  logic        accept_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] ld_data_s;

  // Request decode: normalised function, effective offset, acceptance.
  always_comb begin
    func_s   = mem_func_norm(mem_func_in);
    off_s    = mem_off_align(func_s, addr_in[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    misal_s  = mem_misaligned(func_s, addr_in[1:0]);
`else
    misal_s  = 1'b0;
`endif
    accept_s = (state_r == LSU_IDLE) && valid_in && (load_in != store_in);
  end

  riscv_lsu_align u_align (
    .st_func  (func_s),
    .st_off   (off_s),
    .st_data  (store_data_in),
    .ld_func  (func_r),
    .ld_off   (off_r),
    .ld_rdata (mem_rdata_in),
    .be       (be_s),
    .wdata    (wdata_s),
    .ld_data  (ld_data_s)
  );

  // FSM with registered memory and execute-side outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r        <= LSU_IDLE;
      func_r         <= MEM_FUNC_B;
      off_r          <= 2'b00;
      mem_req_out    <= 1'b0;
      mem_we_out     <= 1'b0;
      mem_addr_out   <= 32'h0000_0000;
      mem_be_out     <= 4'b0000;
      mem_wdata_out  <= 32'h0000_0000;
      result_out     <= 32'h0000_0000;
      done_out       <= 1'b0;
      busy_out       <= 1'b0;
      misaligned_out <= 1'b0;
    end else begin
      done_out       <= 1'b0;
      misaligned_out <= 1'b0;
      case (state_r)
        LSU_IDLE: begin
          if (accept_s) begin
            if (misal_s) begin
              misaligned_out <= 1'b1;
            end else begin
              state_r       <= LSU_REQ;
              busy_out      <= 1'b1;
              mem_req_out   <= 1'b1;
              mem_we_out    <= store_in;
              mem_addr_out  <= {addr_in[31:2], 2'b00};
              mem_be_out    <= be_s;
              mem_wdata_out <= wdata_s;
              func_r        <= func_s;
              off_r         <= off_s;
            end
          end
        end
        LSU_REQ: begin
          if (mem_gnt_in) begin
            mem_req_out <= 1'b0;
            if (mem_we_out) begin
              state_r  <= LSU_IDLE;
              busy_out <= 1'b0;
              done_out <= 1'b1;
            end else begin
              state_r  <= LSU_WAIT;
            end
          end
        end
        LSU_WAIT: begin
          if (mem_rvalid_in) begin
            state_r    <= LSU_IDLE;
            busy_out   <= 1'b0;
            done_out   <= 1'b1;
            result_out <= ld_data_s;
          end
        end
        default: begin
          state_r     <= LSU_IDLE;
          busy_out    <= 1'b0;
          mem_req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// ----------------------------------------------------------------------------
// tb_riscv_lsu -- self-checking bench for riscv_lsu.
// A transaction-level model computes the per-cycle expected outputs from the
// access rules (size, offset arithmetic, sign extension); one negedge process
// compares every output against those expectations each cycle.
// ----------------------------------------------------------------------------
module tb_riscv_lsu;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in, load_in, store_in;
  logic [2:0]  mem_func_in;
  logic [31:0] addr_in, store_data_in;
  logic        mem_req_out, mem_we_out;
  logic [31:0] mem_addr_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_wdata_out;
  logic        mem_gnt_in, mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  logic [31:0] result_out;
  logic        done_out, busy_out, misaligned_out;

  riscv_lsu dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .load_in(load_in),
    .store_in(store_in), .mem_func_in(mem_func_in), .addr_in(addr_in),
    .store_data_in(store_data_in), .mem_req_out(mem_req_out),
    .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_be_out(mem_be_out), .mem_wdata_out(mem_wdata_out),
    .mem_gnt_in(mem_gnt_in), .mem_rvalid_in(mem_rvalid_in),
    .mem_rdata_in(mem_rdata_in), .result_out(result_out),
    .done_out(done_out), .busy_out(busy_out), .misaligned_out(misaligned_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  logic        e_req, e_we, e_done, e_busy, e_mis;
  logic [31:0] e_addr, e_wdata, e_result;
  logic [3:0]  e_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit m_signed(input logic [2:0] f);
    return (f == 3'b000) || (f == 3'b001);
  endfunction

  function automatic bit m_trap(input logic [2:0] f, input logic [31:0] a);
    return (a % m_size(f)) != 0;
  endfunction

  function automatic int m_off(input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = m_size(f);
    return (int'(a % 4) / sz) * sz;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
    logic [7:0] b;
    b = ((8'd1 << m_size(f)) - 8'd1) << m_off(f, a);
    return b[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
    logic [31:0] w;
    int sz;
    sz = m_size(f);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r);
    logic [63:0] v;
    int sz;
    sz = m_size(f);
    v  = {32'd0, r} >> (8 * m_off(f, a));
    v  = v & ((64'd1 << (8 * sz)) - 64'd1);
    if (m_signed(f) && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
    return v[31:0];
  endfunction

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("req", {31'd0, mem_req_out}, {31'd0, e_req});
      chk("done", {31'd0, done_out}, {31'd0, e_done});
      chk("busy", {31'd0, busy_out}, {31'd0, e_busy});
      chk("misaligned", {31'd0, misaligned_out}, {31'd0, e_mis});
      chk("result", result_out, e_result);
      if (e_req) begin
        chk("we", {31'd0, mem_we_out}, {31'd0, e_we});
        chk("addr", mem_addr_out, e_addr);
        chk("be", {28'd0, mem_be_out}, {28'd0, e_be});
        if (e_we) chk("wdata", mem_wdata_out, e_wdata);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; load_in = 1'b0; store_in = 1'b0;
    mem_gnt_in = 1'b0; mem_rvalid_in = 1'b0;
  endtask

  task automatic drive_noise(input bit noise);
    if (noise) begin
      valid_in    = 1'($urandom_range(0, 1));
      load_in     = 1'($urandom_range(0, 1));
      store_in    = 1'($urandom_range(0, 1));
      mem_func_in = 3'($urandom_range(0, 7));
      addr_in     = $urandom;
    end else begin
      valid_in    = 1'b0;
    end
  endtask

  task automatic reset_exp();
    e_req = 1'b0; e_we = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_mis = 1'b0;
    e_addr = 32'd0; e_wdata = 32'd0; e_be = 4'd0; e_result = 32'd0;
  endtask

  // Full access: gd = grant delay, rvd = rvalid delay after WAIT entry,
  // abort: 0 none, 1 reset in first REQ cycle, 2 reset in first WAIT cycle.
  task automatic txn(input bit ld, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] sd, input logic [31:0] rd,
                     input int gd, input int rvd, input int abort, input bit noise);
    valid_in = 1'b1; load_in = ld; store_in = !ld;
    mem_func_in = f; addr_in = a; store_data_in = sd;
    step();
`ifdef LSU_MISALIGN_TRAP_EN
    if (m_trap(f, a)) begin
      idle_inputs();
      e_mis = 1'b1;
      step();
      e_mis = 1'b0;
      return;
    end
`endif
    e_req = 1'b1; e_busy = 1'b1; e_we = !ld;
    e_addr = {a[31:2], 2'b00}; e_be = m_be(f, a); e_wdata = m_wdata(f, sd);
    for (int i = 0; i <= gd; i++) begin
      drive_noise(noise);
      mem_rvalid_in = 1'($urandom_range(0, 1));
      mem_rdata_in  = $urandom;
      if (abort == 1) begin
        rst_in = 1'b1;
        step();
        rst_in = 1'b0; reset_exp(); idle_inputs();
        mem_rvalid_in = 1'b1;
        step();
        mem_rvalid_in = 1'b0;
        return;
      end
      mem_gnt_in = (i == gd);
      step();
    end
    e_req = 1'b0;
    mem_gnt_in = 1'b0;
    if (!ld) begin
      idle_inputs();
      e_busy = 1'b0; e_done = 1'b1;
      step();
      e_done = 1'b0;
      return;
    end
    for (int j = 0; j <= rvd; j++) begin
      drive_noise(noise);
      if (abort == 2) begin
        rst_in = 1'b1; mem_rvalid_in = 1'b0;
        step();
        rst_in = 1'b0; reset_exp(); idle_inputs();
        mem_rvalid_in = 1'b1; mem_rdata_in = rd;
        step();
        mem_rvalid_in = 1'b0;
        return;
      end
      mem_rvalid_in = (j == rvd);
      mem_rdata_in  = (j == rvd) ? rd : $urandom;
      step();
    end
    idle_inputs();
    e_busy = 1'b0; e_done = 1'b1; e_result = m_load(f, a, rd);
    step();
    e_done = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_in = 1'b1;
    idle_inputs();
    mem_func_in = 3'b000; addr_in = 32'd0; store_data_in = 32'd0; mem_rdata_in = 32'd0;
    step();
    reset_exp();
    chk_en = 1'b1;
    step();
    rst_in = 1'b0;
    step();

    // Hand-computed pins on the model itself.
    chk("pin_sb_be", {28'd0, m_be(3'b000, 32'h1003)}, 32'h0000_0008);
    chk("pin_sb_wdata", m_wdata(3'b000, 32'h0000_00AB), 32'hABAB_ABAB);
    chk("pin_lb", m_load(3'b000, 32'h2001, 32'h0000_8000), 32'hFFFF_FF80);
    chk("pin_lbu", m_load(3'b100, 32'h2001, 32'h0000_8000), 32'h0000_0080);
    chk("pin_lh", m_load(3'b001, 32'h2002, 32'h8001_0000), 32'hFFFF_8001);
    chk("pin_lw_be", {28'd0, m_be(3'b010, 32'h3002)}, 32'h0000_000F);
    chk("pin_sh_wdata", m_wdata(3'b001, 32'h1234_5678), 32'h5678_5678);

    // Directed scenarios.
    txn(1'b0, 3'b000, 32'h1003, 32'h0000_00AB, 32'd0, 0, 0, 0, 1'b0);
    txn(1'b1, 3'b000, 32'h2001, 32'd0, 32'h0000_8000, 0, 0, 0, 1'b0);
    txn(1'b1, 3'b100, 32'h2001, 32'd0, 32'h0000_8000, 0, 0, 0, 1'b0);
    txn(1'b1, 3'b001, 32'h2002, 32'd0, 32'h8001_0000, 4, 0, 0, 1'b0);
    txn(1'b1, 3'b010, 32'h2004, 32'd0, 32'hCAFE_F00D, 1, 2, 0, 1'b1);
    txn(1'b1, 3'b101, 32'h2002, 32'd0, 32'h9876_5432, 0, 0, 2, 1'b0);
    txn(1'b1, 3'b010, 32'h3002, 32'd0, 32'h1111_2222, 0, 0, 0, 1'b0);
    txn(1'b0, 3'b111, 32'h4001, 32'h5555_AAAA, 32'd0, 2, 0, 0, 1'b0);
    txn(1'b0, 3'b001, 32'h4001, 32'h0000_BEEF, 32'd0, 0, 0, 1, 1'b0);

    // Randomised traffic with ignored-request noise between accesses.
    for (int k = 0; k < 300; k++) begin
      bit b;
      int ab;
      b = 1'($urandom_range(0, 1));
      valid_in = 1'b1; load_in = b; store_in = b;
      step();
      idle_inputs();
      ab = $urandom_range(0, 39);
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3),
          (ab == 0) ? 1 : ((ab == 1) ? 2 : 0), 1'($urandom_range(0, 1)));
    end

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
